yutorina_bus_arb: RTL and testbench
===================================

YUTORINA_BUS_ARB -- requirements
Module: yutorina_bus_arb

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max cycles an access waits for bus_rdy_ before abort (legal range 2..255).
REQ-002 SHALL have ports, clock and reset first:
- clk in 1: sole clock, rising edge.
- reset_ in 1: asynchronous, active-low reset.
- if_req_ in 1: fetch request, active-low, read-only.
- if_addr in 32: fetch byte address.
- if_rdy_ out 1: fetch done, active-low, one-cycle pulse.
- if_r_data out 32: fetch read data, valid while if_rdy_ low.
- mem_req_ in 1: MEM-stage request, active-low (driven by yutorina_mem_ctrl as_).
- mem_rw in 1: `READ/`WRITE.
- mem_addr in 32: MEM byte address.
- mem_w_data in 32: store data.
- mem_rdy_ out 1: MEM done, active-low, one-cycle pulse.
- mem_r_data out 32: load data, valid while mem_rdy_ low.
- bus_as_ out 1: shared-bus address strobe, active-low.
- bus_rw out 1: shared-bus direction.
- bus_addr out 32, bus_w_data out 32: shared-bus address and write data.
- bus_rdy_ in 1: slave ready, active-low.
- bus_r_data in 32: slave read data.
- bus_err out 1: timeout flag, active-high, one-cycle pulse.

Function
REQ-003 SHALL implement states IDLE, ACC_IF, ACC_MEM; all outputs registered.
REQ-004 In IDLE with mem_req_ low, SHALL go to ACC_MEM and latch mem_rw/mem_addr/mem_w_data into bus_rw/bus_addr/bus_w_data.
REQ-005 In IDLE with mem_req_ high and if_req_ low, SHALL go to ACC_IF, latch if_addr into bus_addr, bus_rw=`READ, bus_w_data=0.
REQ-006 Simultaneous requests SHALL grant MEM (fixed priority); IF waits and is granted the next time it is sampled in IDLE with mem_req_ high.
REQ-007 bus_as_ SHALL be low in every cycle spent in ACC_IF/ACC_MEM and high in IDLE; bus_addr/bus_rw/bus_w_data SHALL hold stable throughout an access.
REQ-008 In ACC_x, bus_rdy_ sampled low SHALL: capture bus_r_data into x_r_data, drive x_rdy_ low for exactly the next cycle, return to IDLE.
REQ-009 Minimum latency: request sampled at edge N, bus_as_ low after N, bus_rdy_ low at N+1 gives x_rdy_ low after N+2.
REQ-010 At least one IDLE cycle SHALL separate consecutive accesses; requester holds req_ low until its rdy_ pulse, and a req_ still low in the rdy_ cycle SHALL be treated as a new request.
REQ-011 A req_ deasserted mid-access SHALL NOT abort the access; completion and rdy_ pulse still occur.
REQ-012 Wait counter SHALL clear on grant, increment each ACC cycle with bus_rdy_ high, and saturate; it SHALL be wide enough for TIMEOUT.
REQ-013 If counter reaches TIMEOUT-1 with bus_rdy_ still high, SHALL abort: x_r_data=0, x_rdy_ pulsed low one cycle, bus_err pulsed high in the same cycle, return to IDLE.
REQ-014 bus_rdy_ low in the same cycle as timeout SHALL count as normal completion, with no bus_err.
REQ-015 bus_rdy_ SHALL be ignored in IDLE.
REQ-016 if_r_data/mem_r_data SHALL hold their last captured value until the next completion of the same port.

Reset
REQ-017 reset_ low SHALL immediately, regardless of clock: force IDLE; set bus_as_, if_rdy_, mem_rdy_ high; set bus_err 0, bus_rw `READ, and bus_addr, bus_w_data, if_r_data, mem_r_data, counter to 0.
REQ-018 Reset during an access SHALL drop the access with no rdy_ pulse; first grant is evaluated at the first edge after reset_ rises.

Verification
REQ-019 mem_req_ low, mem_rw=`WRITE, addr 0x100, data 0xDEADBEEF; bus_rdy_ low 3 cycles later -> bus_as_ low 3 cycles with stable bus signals, then one mem_rdy_ pulse.
REQ-020 if_req_ and mem_req_ low same edge -> ACC_MEM first; ACC_IF follows after one IDLE cycle; if_r_data = 0x12345678 from bus_r_data.
REQ-021 bus_rdy_ held high with TIMEOUT=16 -> after 16 ACC cycles, x_rdy_ pulse with r_data 0 plus coincident bus_err pulse.
REQ-022 reset_ asserted asynchronously mid-ACC_IF -> outputs at reset values before the next clock edge, and no if_rdy_ pulse.
REQ-023 if_req_ released after grant -> access completes and if_rdy_ still pulses once; no second access starts.

Source files
------------

// File: rtl/yutorina_bus_arb.sv
// yutorina_bus_arb: two-master arbiter (instruction fetch and MEM stage) for a
// single shared bus. MEM has fixed priority. An access aborts with bus_err if
// the slave does not answer within TIMEOUT cycles. All outputs are registered.
module yutorina_bus_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        if_req_,
  input  logic [31:0] if_addr,
  output logic        if_rdy_,
  output logic [31:0] if_r_data,
  input  logic        mem_req_,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_w_data,
  output logic        mem_rdy_,
  output logic [31:0] mem_r_data,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_w_data,
  input  logic        bus_rdy_,
  input  logic [31:0] bus_r_data,
  output logic        bus_err
);

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // The counter only needs to reach TIMEOUT-1, where the abort fires.
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_MEM} state_t;

  state_t        r_state,      w_state_next;
  logic [CW-1:0] r_cnt,        w_cnt_next;
  logic          r_as_n,       w_as_n_next;
  logic          r_rw,         w_rw_next;
  logic [31:0]   r_addr,       w_addr_next;
  logic [31:0]   r_w_data,     w_w_data_next;
  logic          r_if_rdy_n,   w_if_rdy_n_next;
  logic [31:0]   r_if_r_data,  w_if_r_data_next;
  logic          r_mem_rdy_n,  w_mem_rdy_n_next;
  logic [31:0]   r_mem_r_data, w_mem_r_data_next;
  logic          r_err,        w_err_next;

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_as_n       <= 1'b1;
      r_rw         <= READ;
      r_addr       <= '0;
      r_w_data     <= '0;
      r_if_rdy_n   <= 1'b1;
      r_if_r_data  <= '0;
      r_mem_rdy_n  <= 1'b1;
      r_mem_r_data <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_as_n       <= w_as_n_next;
      r_rw         <= w_rw_next;
      r_addr       <= w_addr_next;
      r_w_data     <= w_w_data_next;
      r_if_rdy_n   <= w_if_rdy_n_next;
      r_if_r_data  <= w_if_r_data_next;
      r_mem_rdy_n  <= w_mem_rdy_n_next;
      r_mem_r_data <= w_mem_r_data_next;
      r_err        <= w_err_next;
    end
  end

  // Next-state and next-output logic: grant in IDLE, finish or time out in ACC_x.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_as_n_next       = r_as_n;
    w_rw_next         = r_rw;
    w_addr_next       = r_addr;
    w_w_data_next     = r_w_data;
    w_if_rdy_n_next   = 1'b1;
    w_if_r_data_next  = r_if_r_data;
    w_mem_rdy_n_next  = 1'b1;
    w_mem_r_data_next = r_mem_r_data;
    w_err_next        = 1'b0;
    case (r_state)
      IDLE: begin
        w_as_n_next = 1'b1;
        if (!mem_req_) begin
          w_state_next  = ACC_MEM;
          w_as_n_next   = 1'b0;
          w_cnt_next    = '0;
          w_rw_next     = mem_rw;
          w_addr_next   = mem_addr;
          w_w_data_next = mem_w_data;
        end else if (!if_req_) begin
          w_state_next  = ACC_IF;
          w_as_n_next   = 1'b0;
          w_cnt_next    = '0;
          w_rw_next     = READ;
          w_addr_next   = if_addr;
          w_w_data_next = '0;
        end
      end
      ACC_IF, ACC_MEM: begin
        if (!bus_rdy_ || r_cnt == CNT_LAST) begin
          // Slave answer wins over a timeout landing in the same cycle.
          w_state_next = IDLE;
          w_as_n_next  = 1'b1;
          w_err_next   = bus_rdy_;
          if (r_state == ACC_IF) begin
            w_if_rdy_n_next  = 1'b0;
            w_if_r_data_next = bus_rdy_ ? 32'h0 : bus_r_data;
          end else begin
            w_mem_rdy_n_next  = 1'b0;
            w_mem_r_data_next = bus_rdy_ ? 32'h0 : bus_r_data;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_as_n_next  = 1'b1;
      end
    endcase
  end

  assign bus_as_    = r_as_n;
  assign bus_rw     = r_rw;
  assign bus_addr   = r_addr;
  assign bus_w_data = r_w_data;
  assign if_rdy_    = r_if_rdy_n;
  assign if_r_data  = r_if_r_data;
  assign mem_rdy_   = r_mem_rdy_n;
  assign mem_r_data = r_mem_r_data;
  assign bus_err    = r_err;

endmodule

// File: tb/tb_yutorina_bus_arb.sv
// Directed bench for yutorina_bus_arb: a table of per-cycle vectors plus
// hand-written sequences for timeout, timeout boundary and async reset.
module tb_yutorina_bus_arb;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef struct packed {
    logic        if_req_n;
    logic [31:0] if_addr;
    logic        mem_req_n;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic        bus_rdy_n;
    logic [31:0] bus_r_data;
  } ins_t;

  typedef struct packed {
    logic        as_n;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        if_rdy_n;
    logic [31:0] if_r_data;
    logic        mem_rdy_n;
    logic [31:0] mem_r_data;
    logic        err;
  } outs_t;

  typedef struct {
    ins_t  i;
    outs_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_ = 1'b1;
  logic        if_req_ = 1'b1;
  logic [31:0] if_addr = '0;
  logic        if_rdy_;
  logic [31:0] if_r_data;
  logic        mem_req_ = 1'b1;
  logic        mem_rw = RD;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_w_data = '0;
  logic        mem_rdy_;
  logic [31:0] mem_r_data;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_addr;
  logic [31:0] bus_w_data;
  logic        bus_rdy_ = 1'b1;
  logic [31:0] bus_r_data = '0;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  yutorina_bus_arb #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_(reset_),
    .if_req_(if_req_), .if_addr(if_addr), .if_rdy_(if_rdy_), .if_r_data(if_r_data),
    .mem_req_(mem_req_), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_rdy_(mem_rdy_), .mem_r_data(mem_r_data),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_w_data(bus_w_data),
    .bus_rdy_(bus_rdy_), .bus_r_data(bus_r_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic ins_t vin(logic iq, logic [31:0] ia, logic mq, logic rw,
                               logic [31:0] ma, logic [31:0] mw, logic br, logic [31:0] bd);
    return '{iq, ia, mq, rw, ma, mw, br, bd};
  endfunction

  function automatic outs_t vout(logic as_n, logic rw, logic [31:0] a, logic [31:0] wd,
                                 logic ir, logic [31:0] id, logic mr, logic [31:0] md, logic e);
    return '{as_n, rw, a, wd, ir, id, mr, md, e};
  endfunction

  function automatic outs_t sample();
    return '{bus_as_, bus_rw, bus_addr, bus_w_data, if_rdy_, if_r_data,
             mem_rdy_, mem_r_data, bus_err};
  endfunction

  task automatic set_in(input ins_t v);
    if_req_    = v.if_req_n;
    if_addr    = v.if_addr;
    mem_req_   = v.mem_req_n;
    mem_rw     = v.mem_rw;
    mem_addr   = v.mem_addr;
    mem_w_data = v.mem_w_data;
    bus_rdy_   = v.bus_rdy_n;
    bus_r_data = v.bus_r_data;
  endtask

  task automatic chk_outs(input string nm, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: as_=%b rw=%b addr=%h if_rdy_=%b if_d=%h mem_rdy_=%b mem_d=%h err=%b",
               nm, act.as_n, act.rw, act.addr, act.if_rdy_n, act.if_r_data,
               act.mem_rdy_n, act.mem_r_data, act.err);
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t  vecs[18];
  outs_t rst_vals;

  initial begin
    int n;
    int as_low;
    bit seen;
    bit pulse;

    rst_vals = vout(1, RD, 32'h0, 32'h0, 1, 32'h0, 1, 32'h0, 0);

    // MEM write, slave answers on the third strobe cycle
    vecs[0]  = '{vin(1, 32'h0, 0, WR, 32'h100, 32'hDEADBEEF, 1, 32'h0),
                 vout(0, WR, 32'h100, 32'hDEADBEEF, 1, 32'h0, 1, 32'h0, 0)};
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = '{vin(1, 32'h0, 0, WR, 32'h100, 32'hDEADBEEF, 0, 32'h0),
                 vout(1, WR, 32'h100, 32'hDEADBEEF, 1, 32'h0, 0, 32'h0, 0)};
    vecs[4]  = '{vin(1, 32'h0, 1, WR, 32'h100, 32'hDEADBEEF, 1, 32'h0),
                 vout(1, WR, 32'h100, 32'hDEADBEEF, 1, 32'h0, 1, 32'h0, 0)};
    // Simultaneous requests: MEM read first, IF after one IDLE cycle
    vecs[5]  = '{vin(0, 32'h400, 0, RD, 32'h200, 32'h11112222, 1, 32'h0),
                 vout(0, RD, 32'h200, 32'h11112222, 1, 32'h0, 1, 32'h0, 0)};
    vecs[6]  = '{vin(0, 32'h400, 0, RD, 32'h200, 32'h11112222, 0, 32'hCAFEF00D),
                 vout(1, RD, 32'h200, 32'h11112222, 1, 32'h0, 0, 32'hCAFEF00D, 0)};
    vecs[7]  = '{vin(0, 32'h400, 1, RD, 32'h200, 32'h11112222, 1, 32'h0),
                 vout(0, RD, 32'h400, 32'h0, 1, 32'h0, 1, 32'hCAFEF00D, 0)};
    vecs[8]  = '{vin(0, 32'h400, 1, RD, 32'h200, 32'h11112222, 0, 32'h12345678),
                 vout(1, RD, 32'h400, 32'h0, 0, 32'h12345678, 1, 32'hCAFEF00D, 0)};
    vecs[9]  = '{vin(1, 32'h400, 1, RD, 32'h200, 32'h11112222, 1, 32'h0),
                 vout(1, RD, 32'h400, 32'h0, 1, 32'h12345678, 1, 32'hCAFEF00D, 0)};
    // bus_rdy_ low in IDLE is ignored
    vecs[10] = '{vin(1, 32'h0, 1, WR, 32'h500, 32'h0, 0, 32'hFFFFFFFF),
                 vout(1, RD, 32'h400, 32'h0, 1, 32'h12345678, 1, 32'hCAFEF00D, 0)};
    // IF req held through its rdy_ cycle starts a second access
    vecs[11] = '{vin(0, 32'h800, 1, WR, 32'h500, 32'h0, 1, 32'h0),
                 vout(0, RD, 32'h800, 32'h0, 1, 32'h12345678, 1, 32'hCAFEF00D, 0)};
    vecs[12] = '{vin(0, 32'h800, 1, WR, 32'h500, 32'h0, 0, 32'h0BADBEEF),
                 vout(1, RD, 32'h800, 32'h0, 0, 32'h0BADBEEF, 1, 32'hCAFEF00D, 0)};
    vecs[13] = '{vin(0, 32'h804, 1, WR, 32'h500, 32'h0, 1, 32'h0),
                 vout(0, RD, 32'h804, 32'h0, 1, 32'h0BADBEEF, 1, 32'hCAFEF00D, 0)};
    // IF req released mid-access: access still completes, no new one
    vecs[14] = '{vin(1, 32'h0, 1, WR, 32'h500, 32'h0, 1, 32'h0),
                 vout(0, RD, 32'h804, 32'h0, 1, 32'h0BADBEEF, 1, 32'hCAFEF00D, 0)};
    vecs[15] = '{vin(1, 32'h0, 1, WR, 32'h500, 32'h0, 0, 32'h55AA55AA),
                 vout(1, RD, 32'h804, 32'h0, 0, 32'h55AA55AA, 1, 32'hCAFEF00D, 0)};
    vecs[16] = '{vin(1, 32'h0, 1, WR, 32'h500, 32'h0, 1, 32'h0),
                 vout(1, RD, 32'h804, 32'h0, 1, 32'h55AA55AA, 1, 32'hCAFEF00D, 0)};
    vecs[17] = vecs[16];

    // Reset state, checked before any clock edge
    #2 reset_ = 1'b0;
    #1 chk_outs("reset_state", sample(), rst_vals);
    step();
    step();
    #2 reset_ = 1'b1;

    for (int v = 0; v < 18; v++) begin
      set_in(vecs[v].i);
      step();
      chk_outs($sformatf("vec%0d", v), sample(), vecs[v].o);
    end

    // Timeout abort: bus_rdy_ never answers
    set_in(vin(1, 32'h0, 0, RD, 32'h300, 32'h0, 1, 32'h0));
    step();
    chk_val("to_grant_as", {31'h0, bus_as_}, 32'h0);
    as_low = 1;
    n = 0;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!mem_rdy_) begin
        seen = 1;
        n = k;
        break;
      end
      if (!bus_as_) as_low++;
    end
    mem_req_ = 1'b1;
    chk_val("to_seen", {31'h0, seen}, 32'h1);
    chk_val("to_edges", n, 16);
    chk_val("to_as_cycles", as_low, 16);
    chk_val("to_err", {31'h0, bus_err}, 32'h1);
    chk_val("to_as_high", {31'h0, bus_as_}, 32'h1);
    chk_val("to_rdata", mem_r_data, 32'h0);
    step();
    chk_val("to_err_pulse", {30'h0, bus_err, mem_rdy_}, 32'h1);

    // Timeout boundary: answer on the very cycle the counter hits its limit
    set_in(vin(1, 32'h0, 0, RD, 32'h304, 32'h0, 1, 32'h0));
    step();
    pulse = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (!mem_rdy_ || bus_as_) pulse = 1;
    end
    chk_val("tb_no_early_end", {31'h0, pulse}, 32'h0);
    bus_rdy_ = 1'b0;
    bus_r_data = 32'h600DD00D;
    step();
    mem_req_ = 1'b1;
    bus_rdy_ = 1'b1;
    chk_val("tb_rdy", {31'h0, mem_rdy_}, 32'h0);
    chk_val("tb_no_err", {31'h0, bus_err}, 32'h0);
    chk_val("tb_rdata", mem_r_data, 32'h600DD00D);
    step();

    // Async reset in the middle of an IF access
    set_in(vin(0, 32'h900, 1, RD, 32'h0, 32'h0, 1, 32'h0));
    step();
    chk_val("ar_grant_as", {31'h0, bus_as_}, 32'h0);
    #3 reset_ = 1'b0;
    if_req_ = 1'b1;
    #1 chk_outs("ar_async", sample(), rst_vals);
    pulse = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (!if_rdy_ || !bus_as_) pulse = 1;
    end
    chk_val("ar_no_pulse", {31'h0, pulse}, 32'h0);
    // First grant happens at the first edge after reset_ rises
    set_in(vin(1, 32'h0, 0, RD, 32'h700, 32'h0, 1, 32'h0));
    #3 reset_ = 1'b1;
    step();
    chk_val("ar_first_grant", {bus_addr[30:0], bus_as_}, {31'h700, 1'b0});
    bus_rdy_ = 1'b0;
    bus_r_data = 32'hA5A5A5A5;
    step();
    mem_req_ = 1'b1;
    bus_rdy_ = 1'b1;
    chk_val("ar_complete", mem_r_data, 32'hA5A5A5A5);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
